// File: rtl/bram_rd_pkg.sv
// Shared definitions for the top-row BRAM read path.
//   ADDR_W     : BRAM row address / offset width
//   CNT_W      : width of the x, y and feature-map counters
//   RD_LATENCY : edges from the read-request pulse rising to the edge that
//                samples the row reader's `last`
//   state_t    : scheduler state encoding
package bram_rd_pkg;

  localparam int ADDR_W     = 13;
  localparam int CNT_W      = 10;
  localparam int RD_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADV,
    DONE
  } state_t;

endpackage

// File: rtl/bram_row_rd_sched.sv
// bram_row_rd_sched
// Walks every patch (x, y) of a bar and every bottom feature map i, issuing
// one row-read request per (x, y, i) to the row reader and waiting for its
// `last` before moving on. Loop order: i innermost, then y, then x.
// Offset = x*num_y + y + i*fm_stride (mod 2^ADDR_W), built incrementally.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start                       : one-cycle pulse, latches cfg_* and begins a pass
//   cfg_num_x/_num_y/_num_fm    : loop counts (any zero -> empty pass)
//   cfg_fm_stride               : address stride between feature maps
//   row_ready                   : consumer can accept the next row
//   rd_data_bram_row_last       : last-valid strobe from the row reader
//   rd_data_bottom              : one-cycle read-request pulse
//   rd_data_bram_row_ith_offset : row address, stable from pulse until `last`
//   busy                        : pass in progress
//   done                        : one-cycle pulse at the end of a pass
module bram_row_rd_sched #(
  parameter int ADDR_W = bram_rd_pkg::ADDR_W,
  parameter int CNT_W  = bram_rd_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_num_x,
  input  logic [CNT_W-1:0]  cfg_num_y,
  input  logic [CNT_W-1:0]  cfg_num_fm,
  input  logic [ADDR_W-1:0] cfg_fm_stride,
  input  logic              row_ready,
  input  logic              rd_data_bram_row_last,
  output logic              rd_data_bottom,
  output logic [ADDR_W-1:0] rd_data_bram_row_ith_offset,
  output logic              busy,
  output logic              done
);
  import bram_rd_pkg::*;

  state_t            r_state, w_state_next;

  logic [CNT_W-1:0]  r_num_x, r_num_y, r_num_fm;
  logic [ADDR_W-1:0] r_fm_stride;

  logic [CNT_W-1:0]  r_x, r_y, r_i;
  logic [CNT_W-1:0]  w_x_next, w_y_next, w_i_next;
  logic [ADDR_W-1:0] r_row_base, r_fm_base;
  logic [ADDR_W-1:0] w_row_base_next, w_fm_base_next;

  logic              r_rd_pulse, r_busy, r_done;
  logic [ADDR_W-1:0] r_offset;

  logic              w_start_ok, w_zero_cfg;
  logic              w_i_last, w_y_last, w_x_last, w_final;

  // busy stays high for the cycle after DONE (registered output), so the
  // registered flag also gates start to honour "ignored while busy".
  assign w_start_ok = start && (r_state == IDLE) && !r_busy;
  assign w_zero_cfg = (cfg_num_x == '0) || (cfg_num_y == '0) || (cfg_num_fm == '0);

  assign w_i_last = (r_i == r_num_fm - CNT_W'(1));
  assign w_y_last = (r_y == r_num_y  - CNT_W'(1));
  assign w_x_last = (r_x == r_num_x  - CNT_W'(1));
  assign w_final  = w_i_last && w_y_last && w_x_last;

  always_comb begin
    w_state_next    = r_state;
    w_x_next        = r_x;
    w_y_next        = r_y;
    w_i_next        = r_i;
    w_row_base_next = r_row_base;
    w_fm_base_next  = r_fm_base;

    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_x_next        = '0;
          w_y_next        = '0;
          w_i_next        = '0;
          w_row_base_next = '0;
          w_fm_base_next  = '0;
          w_state_next    = w_zero_cfg ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (row_ready) w_state_next = WAIT;
      end
      WAIT: begin
        if (rd_data_bram_row_last) w_state_next = ADV;
      end
      ADV: begin
        if (w_final) begin
          // Counters are left alone so the offset of the final row holds.
          w_state_next = DONE;
        end else begin
          w_state_next = ISSUE;
          if (!w_i_last) begin
            w_i_next       = r_i + CNT_W'(1);
            w_fm_base_next = r_fm_base + r_fm_stride;
          end else begin
            // i wraps; x*num_y + y is contiguous, so the row base moves by
            // one whether y steps or y wraps and x steps.
            w_i_next        = '0;
            w_fm_base_next  = '0;
            w_row_base_next = r_row_base + ADDR_W'(1);
            if (!w_y_last) begin
              w_y_next = r_y + CNT_W'(1);
            end else begin
              w_y_next = '0;
              w_x_next = r_x + CNT_W'(1);
            end
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_num_x     <= '0;
      r_num_y     <= '0;
      r_num_fm    <= '0;
      r_fm_stride <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_i         <= '0;
      r_row_base  <= '0;
      r_fm_base   <= '0;
      r_rd_pulse  <= 1'b0;
      r_offset    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_i        <= w_i_next;
      r_row_base <= w_row_base_next;
      r_fm_base  <= w_fm_base_next;

      if (w_start_ok) begin
        r_num_x     <= cfg_num_x;
        r_num_y     <= cfg_num_y;
        r_num_fm    <= cfg_num_fm;
        r_fm_stride <= cfg_fm_stride;
      end

      // Bases only move on start or in ADV, so the offset is stable
      // through ISSUE stalls and WAIT.
      r_offset   <= w_row_base_next + w_fm_base_next;
      r_rd_pulse <= (r_state == ISSUE) && row_ready;
      r_busy     <= (r_state != IDLE);
      r_done     <= (r_state == DONE);
    end
  end

  assign rd_data_bottom              = r_rd_pulse;
  assign rd_data_bram_row_ith_offset = r_offset;
  assign busy                        = r_busy;
  assign done                        = r_done;

endmodule

// File: tb/tb_bram_row_rd_sched.sv
// Testbench for bram_row_rd_sched. A behavioural rd_bram_row responder
// answers every read pulse with `last`; expected offsets come from nested
// loops over (x, y, i) using plain multiplication.
module tb_bram_row_rd_sched;
  import bram_rd_pkg::*;

  localparam int AW = ADDR_W;
  localparam int CW = CNT_W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cfg_num_x, cfg_num_y, cfg_num_fm;
  logic [AW-1:0] cfg_fm_stride;
  logic          row_ready;
  logic          last_in;
  logic          rd_data_bottom;
  logic [AW-1:0] offset;
  logic          busy;
  logic          done;

  logic          resp_last;
  logic          stray_last;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int unsigned pulse_off[$];
  int          pulse_cyc[$];
  logic [AW-1:0] last_off = '0;

  bram_row_rd_sched dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .start                       (start),
    .cfg_num_x                   (cfg_num_x),
    .cfg_num_y                   (cfg_num_y),
    .cfg_num_fm                  (cfg_num_fm),
    .cfg_fm_stride               (cfg_fm_stride),
    .row_ready                   (row_ready),
    .rd_data_bram_row_last       (last_in),
    .rd_data_bottom              (rd_data_bottom),
    .rd_data_bram_row_ith_offset (offset),
    .busy                        (busy),
    .done                        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // rd_bram_row responder: `last` is sampled RD_LATENCY edges after the
  // edge on which the request pulse rises.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_last <= 1'b0;
    else        resp_last <= rd_data_bottom;
  end
  assign last_in = resp_last | stray_last;

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Monitor: record each pulse, count busy cycles, and check that the offset
  // is still the pulsed one when the reader answers.
  always @(negedge clk) begin
    if (rd_data_bottom) begin
      pulse_off.push_back(int'(offset));
      pulse_cyc.push_back(cyc);
      last_off = offset;
    end
    if (busy) busy_cnt++;
    if (resp_last) check_eq("offset_hold", int'(offset), int'(last_off));
  end

  task automatic run_pass(input int nx, input int ny, input int nfm, input int stride,
                          input bit timing, input bit do_stall, input bit rnd_ready);
    int unsigned exp_q[$];
    int n, base, bbase, start_edge, done_edge, budget, pulses, since, got_n, extra;
    bit got;
    for (int x = 0; x < nx; x++)
      for (int y = 0; y < ny; y++)
        for (int i = 0; i < nfm; i++)
          exp_q.push_back(int'((x * ny + y + i * stride) % (1 << AW)));
    n     = exp_q.size();
    base  = pulse_off.size();
    bbase = busy_cnt;
    extra = do_stall ? 5 : 0;

    @(negedge clk);
    row_ready     = 1'b1;
    cfg_num_x     = CW'(nx);
    cfg_num_y     = CW'(ny);
    cfg_num_fm    = CW'(nfm);
    cfg_fm_stride = AW'(stride);
    start         = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    start_edge = cyc;
    // Configuration is latched; scramble the inputs.
    cfg_num_x     = CW'($urandom);
    cfg_num_y     = CW'($urandom);
    cfg_num_fm    = CW'($urandom);
    cfg_fm_stride = AW'($urandom);

    budget = 16 * n + 64;
    got = 1'b0; pulses = 0; since = -1; done_edge = 0;
    while (!got && budget > 0) begin
      @(negedge clk);
      budget--;
      if (rnd_ready) row_ready = ($urandom_range(3) != 0);
      if (done) begin
        got = 1'b1;
        done_edge = cyc + 1;
      end
      if (rd_data_bottom) begin
        pulses++;
        if (do_stall && pulses == 3) since = 0;
      end else if (since >= 0) begin
        since++;
        case (since)
          3: begin
            row_ready = 1'b0;
            start     = 1'b1;
            check_eq("stall_off_a", int'(offset), int'(exp_q[3]));
          end
          4: begin
            start      = 1'b0;
            stray_last = 1'b1;
          end
          5: stray_last = 1'b0;
          7: check_eq("stall_off_b", int'(offset), int'(exp_q[3]));
          8: begin
            row_ready = 1'b1;
            since = -1;
          end
          default: ;
        endcase
      end
    end
    row_ready = 1'b1;
    check_eq("done_seen", int'(got), 1);
    repeat (2) @(negedge clk);

    got_n = pulse_off.size() - base;
    check_eq("pulse_count", got_n, n);
    for (int k = 0; k < n && k < got_n; k++)
      check_eq($sformatf("off%0d", k), int'(pulse_off[base + k]), int'(exp_q[k]));
    if (timing) begin
      check_eq("latency", done_edge - start_edge, 4 * n + 2 + extra);
      check_eq("busy_cycles", busy_cnt - bbase, 4 * n + 1 + extra);
      if (n > 0 && got_n > 0)
        check_eq("first_pulse", pulse_cyc[base], start_edge + 1);
      if (do_stall && got_n > 3)
        check_eq("stall_gap", pulse_cyc[base + 3] - pulse_cyc[base + 2], 4 + extra);
    end
  endtask

  initial begin
    int wb, cnt, bud;
    start = 1'b0; row_ready = 1'b1; stray_last = 1'b0;
    cfg_num_x = '0; cfg_num_y = '0; cfg_num_fm = '0; cfg_fm_stride = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pulse", int'(rd_data_bottom), 0);
    check_eq("rst_offset", int'(offset), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic pass: offsets 0,100,1,101,...; done 50 cycles after start.
    run_pass(2, 3, 2, 100, 1'b1, 1'b0, 1'b0);
    // Backpressure with a spurious start and a stray last during the stall.
    run_pass(2, 3, 2, 100, 1'b1, 1'b1, 1'b0);
    // Zero configuration.
    run_pass(3, 2, 0, 7, 1'b1, 1'b0, 1'b0);
    run_pass(0, 4, 2, 7, 1'b1, 1'b0, 1'b0);
    // Wrap-around of the second feature map's offsets.
    wb = pulse_off.size();
    run_pass(1, 300, 2, 8000, 1'b1, 1'b0, 1'b0);
    if (pulse_off.size() >= wb + 600)
      check_eq("wrap_y299", int'(pulse_off[wb + 599]), 107);

    // Randomized passes with random row_ready.
    for (int r = 0; r < 6; r++)
      run_pass($urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(0, 3),
               int'($urandom_range(0, (1 << AW) - 1)), 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a pass, during WAIT while the second pulse is out.
    @(negedge clk);
    cfg_num_x = CW'(2); cfg_num_y = CW'(3); cfg_num_fm = CW'(2);
    cfg_fm_stride = AW'(100); row_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; bud = 100;
    while (cnt < 2 && bud > 0) begin
      @(negedge clk);
      bud--;
      if (rd_data_bottom) cnt++;
    end
    check_eq("rst_reach", cnt, 2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_pulse", int'(rd_data_bottom), 0);
    check_eq("midrst_offset", int'(offset), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_pass(2, 3, 2, 100, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed %0d expected %0d", cyc, 0);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/bram_row_rd_sched.md
# bram_row_rd_sched

Sequencer for the top-row BRAM read path in the fully-connected/conv bottom-data pipeline. On `start`, it walks every patch (x, y) of the current bar and every bottom feature map i. For each row it issues one read request to the row reader: a single-cycle `rd_data_bottom` pulse plus a stable offset. It waits for the reader's `last`, then advances. It sits between the layer control FSM (configuration, start/done) and `rd_bram_row`, and it throttles on downstream `row_ready`.

## Interface
- `ADDR_W`, 13, BRAM row address / offset width.
- `CNT_W`, 10, width of the x, y and feature-map counters.
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `start` in 1 — one-cycle pulse; latches the `cfg_*` inputs and begins a pass; ignored while `busy`.
- `cfg_num_x` in CNT_W — patch rows per bar.
- `cfg_num_y` in CNT_W — patch columns per bar (= `num_of_patch_in_one_bar`).
- `cfg_num_fm` in CNT_W — bottom feature maps.
- `cfg_fm_stride` in ADDR_W — address stride between feature maps.
- `row_ready` in 1 — consumer can accept the next row.
- `rd_data_bram_row_last` in 1 — last-valid strobe from the row reader.
- `rd_data_bottom` out 1 — read-request pulse to the row reader.
- `rd_data_bram_row_ith_offset` out ADDR_W — row address; held stable from the pulse until `last` is seen.
- `busy` out 1 — a pass is in progress.
- `done` out 1 — one-cycle pulse at the end of a pass.

## Operation
- Loop order: i innermost, then y, then x outermost.
- Offset = x·cfg_num_y + y + i·cfg_fm_stride, truncated mod 2^ADDR_W.
- Offset is computed incrementally with no multiplier:
  - `row_base` += 1 per y step; it also increments by 1 per x step, since y wraps to 0 and x·num_y + y is contiguous.
  - `fm_base` += cfg_fm_stride per i step; it resets to 0 on i wrap.
- States:
  - IDLE: `start` → if any cfg count is 0, go to DONE; else clear counters and go to ISSUE.
  - ISSUE: if `row_ready`, assert `rd_data_bottom` for one cycle and go to WAIT; else stay.
  - WAIT: on `rd_data_bram_row_last`, go to ADV.
  - ADV: step the counters. If (i, y, x) were all at their maxima, go to DONE; else go to ISSUE.
  - DONE: assert `done` for one cycle, go to IDLE.
- `busy` = state ∉ {IDLE}. `done` pulses from DONE; `busy` is still high in that cycle.
- Ignore `last` outside WAIT.
- `start` while busy has no effect.
- The `cfg_*` inputs may change freely after the `start` cycle.
- Reset at any time returns to IDLE, clears all counters, and drives every output to 0.

## Timing
- All outputs are registered. Reset values:
  - `rd_data_bottom`=0, `rd_data_bram_row_ith_offset`=0, `busy`=0, `done`=0.
- `start` is sampled at edge t. The first pulse occupies cycle t+1 to t+2, provided `row_ready` is high at t+1; the offset is valid in the same cycle.
- The row reader returns `last` 2 cycles after the pulse cycle. The scheduler reaches ADV 1 cycle later, and the next pulse follows 1 cycle after that.
- Steady state is therefore one row per 4 cycles.
- Offset changes only in ADV; it holds through ISSUE stalls and WAIT.
- A `row_ready` deassertion during WAIT has no effect. It is checked only in ISSUE.
- A pass costs 4·N_rows + 2 cycles from `start` to `done` with no stalls, where N_rows = num_x·num_y·num_fm.
- Any zero count: `done` pulses at t+2, with no read issued.

## Structure
- Shared package `bram_rd_pkg`:
  - `ADDR_W` and `CNT_W` constants.
  - state enum `{IDLE, ISSUE, WAIT, ADV, DONE}`.
  - reader read latency constant (2).
- No sub-module. The three wrap counters stay inline.
- The bench instantiates `rd_bram_row` as the responder.

## Test plan
- **Basic pass:** num_x=2, num_y=3, num_fm=2, stride=100, `row_ready`=1. Expected:
  - 12 pulses with offsets 0,100,1,101,2,102,3,103,4,104,5,105.
  - `done` 50 cycles after `start`.
- **Backpressure:** drop `row_ready` for 5 cycles during ISSUE. Expected:
  - pulse delayed by exactly 5 cycles.
  - offset unchanged across the stall.
  - no duplicate pulse.
- **Zero config:** num_fm=0, then `start`. Expected:
  - no `rd_data_bottom`.
  - `done` at t+2.
  - `busy` high only during t+1 to t+2.
- **Wrap-around:** stride=8000, num_fm=2, num_x=1, num_y=300. Expected: second-fm offsets wrap mod 8192, e.g. y=299 → 8299 mod 8192 = 107.
- **Spurious inputs:**
  - `start` pulsed mid-pass is ignored.
  - a stray `last` in ISSUE causes no advance.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT. Expected:
  - all outputs 0 immediately.
  - after release, a fresh `start` begins again at offset 0.
